// File: rtl/monster_hit_reporter_if.sv
// ----------------------------------------------------------------------------
// monster_hit_reporter_if
//   Valid/ready command channel from the hit reporter to the monster grid
//   bitmap block. One command decrements one grid cell.
//
//   hitValid : command available (driven by master)
//   hitRow   : cell row 0..7     (driven by master)
//   hitCol   : cell column 0..15 (driven by master)
//   hitReady : grid block accepts the command this cycle (driven by slave)
// ----------------------------------------------------------------------------
interface monster_hit_reporter_if;
    logic       hitValid;
    logic       hitReady;
    logic [2:0] hitRow;
    logic [3:0] hitCol;

    modport master (
        output hitValid,
        output hitRow,
        output hitCol,
        input  hitReady
    );

    modport slave (
        input  hitValid,
        input  hitRow,
        input  hitCol,
        output hitReady
    );
endinterface

// File: rtl/monster_hit_reporter.sv
// ----------------------------------------------------------------------------
// monster_hit_reporter
//   Turns per-pixel monster/missile collision pulses into at most one
//   decrement command per grid cell per frame, queues the commands in a small
//   FIFO and presents them on a valid/ready channel. Also counts the monster
//   hit points still left in the level.
//
//   Parameters
//     FIFO_DEPTH : pending commands held, including the one being presented
//                  (power of 2, 2..8)
//     TOTAL_HITS : hit points loaded at reset and on newLevel (1..1023)
//
//   Ports
//     clk             : system clock
//     resetN          : asynchronous active-low reset
//     startOfFrame    : one-cycle pulse, clears the per-frame dedupe bitmap
//     newLevel        : one-cycle pulse, flushes FIFO/bitmap, reloads counter
//     collision       : monster/missile overlap at the current pixel
//     InsideRectangle : current pixel lies inside the monster grid
//     offsetX/offsetY : pixel offset from the grid top-left corner
//     hit             : command channel (master side)
//     remaining       : hit points left
//     allClear        : remaining == 0
//     dropPulse       : one-cycle pulse when a new hit was lost (FIFO full)
// ----------------------------------------------------------------------------
module monster_hit_reporter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TOTAL_HITS = 80
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic                         newLevel,
    input  logic                         collision,
    input  logic                         InsideRectangle,
    input  logic [10:0]                  offsetX,
    input  logic [10:0]                  offsetY,
    monster_hit_reporter_if.master       hit,
    output logic [9:0]                   remaining,
    output logic                         allClear,
    output logic                         dropPulse
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [9:0]  RELOAD = 10'(TOTAL_HITS);

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [6:0]    mem_q [FIFO_DEPTH];
    logic [6:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // Registered head presentation
    logic          valid_q, valid_d;
    logic [2:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;

    // One bit per grid cell: already reported this frame
    logic [127:0]  hit_frame_q, hit_frame_d;

    logic [9:0]    remaining_q, remaining_d;
    logic          drop_q, drop_d;

    logic [6:0]    cell_idx;
    logic          qualified;
    logic          fifo_full;
    logic          pop;
    logic          push;

    // Low five offset bits select the pixel within a 32x32 cell
    logic          unused_pixel_bits;
    assign unused_pixel_bits = ^{offsetX[4:0], offsetY[4:0]};

    assign cell_idx  = {offsetY[7:5], offsetX[8:5]};
    assign qualified = collision && InsideRectangle &&
                       (offsetY[10:8] == 3'd0) && (offsetX[10:9] == 2'd0);
    assign fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // valid_q always mirrors "FIFO not empty", so it doubles as the pop gate
    assign pop       = valid_q && hit.hitReady && !newLevel;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        valid_d     = valid_q;
        row_d       = row_q;
        col_d       = col_q;
        hit_frame_d = hit_frame_q;
        remaining_d = remaining_q;
        drop_d      = 1'b0;
        push        = 1'b0;

        if (newLevel) begin
            hit_frame_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            valid_d     = 1'b0;
            remaining_d = RELOAD;
        end else begin
            // Frame clear happens before the same-cycle hit is recorded
            if (startOfFrame) begin
                hit_frame_d = '0;
            end

            if (qualified && !hit_frame_d[cell_idx]) begin
                hit_frame_d[cell_idx] = 1'b1;
                if (!fifo_full || pop) begin
                    push = 1'b1;
                end else begin
                    drop_d = 1'b1;
                end
            end

            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = cell_idx;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end

            if (pop) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                remaining_d = (remaining_q == 10'd0) ? 10'd0 : remaining_q - 10'd1;
            end

            // Next head read from the post-write array so a push into an empty
            // FIFO is presented on the following cycle without a bubble
            valid_d = (wr_ptr_d != rd_ptr_d);
            if (valid_d) begin
                {row_d, col_d} = mem_d[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            valid_q     <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            hit_frame_q <= '0;
            remaining_q <= RELOAD;
            drop_q      <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            valid_q     <= valid_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hit_frame_q <= hit_frame_d;
            remaining_q <= remaining_d;
            drop_q      <= drop_d;
        end
    end

    assign hit.hitValid = valid_q;
    assign hit.hitRow   = row_q;
    assign hit.hitCol   = col_q;
    assign remaining    = remaining_q;
    assign allClear     = (remaining_q == 10'd0);
    assign dropPulse    = drop_q;

endmodule

// File: tb/tb_monster_hit_reporter.sv
module tb_monster_hit_reporter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN;
    logic        startOfFrame;
    logic        newLevel;
    logic        collision;
    logic        InsideRectangle;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [9:0]  remaining, remaining2;
    logic        allClear, allClear2;
    logic        dropPulse, dropPulse2;

    monster_hit_reporter_if hif ();
    monster_hit_reporter_if hif2 ();

    monster_hit_reporter #(.FIFO_DEPTH(4), .TOTAL_HITS(80)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .newLevel(newLevel),
        .collision(collision), .InsideRectangle(InsideRectangle),
        .offsetX(offsetX), .offsetY(offsetY), .hit(hif),
        .remaining(remaining), .allClear(allClear), .dropPulse(dropPulse)
    );

    monster_hit_reporter #(.FIFO_DEPTH(4), .TOTAL_HITS(2)) dut2 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .newLevel(newLevel),
        .collision(collision), .InsideRectangle(InsideRectangle),
        .offsetX(offsetX), .offsetY(offsetY), .hit(hif2),
        .remaining(remaining2), .allClear(allClear2), .dropPulse(dropPulse2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] exp_q [$];
    logic [6:0] mon_e;

    typedef struct {
        int ox; int oy; bit ins; bit coll;
        bit qual; int row; int col;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] mk(input int r, input int c);
        return 7'(r * 16 + c);
    endfunction

    // Scoreboard: each accepted handshake must match the oldest expected cell
    always @(negedge clk) begin
        if (resetN === 1'b1 && !newLevel && hif.hitValid && hif.hitReady) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_cmd: got row %0d col %0d expected none",
                         hif.hitRow, hif.hitCol);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_cell", int'({hif.hitRow, hif.hitCol}), int'(mon_e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        resetN = 1'b0;
        startOfFrame = 1'b0; newLevel = 1'b0; collision = 1'b0;
        InsideRectangle = 1'b0; offsetX = '0; offsetY = '0;
        exp_q.delete();
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic hit(input int ox, input int oy, input bit ins, input bit coll);
        offsetX = 11'(ox);
        offsetY = 11'(oy);
        InsideRectangle = ins;
        collision = coll;
        tick();
        collision = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        int nqual;

        tbl[0]  = '{520, 40, 1, 1, 0, 0, 0};
        tbl[1]  = '{70, 40, 0, 1, 0, 0, 0};
        tbl[2]  = '{70, 300, 1, 1, 0, 0, 0};
        tbl[3]  = '{70, 40, 1, 0, 0, 0, 0};
        tbl[4]  = '{511, 255, 1, 1, 1, 7, 15};
        tbl[5]  = '{8, 40, 1, 1, 1, 1, 0};
        tbl[6]  = '{70, 40, 1, 1, 1, 1, 2};
        tbl[7]  = '{100, 200, 1, 1, 1, 6, 3};
        tbl[8]  = '{0, 0, 1, 1, 1, 0, 0};
        tbl[9]  = '{511, 255, 1, 1, 0, 0, 0};
        tbl[10] = '{1000, 40, 1, 1, 0, 0, 0};
        tbl[11] = '{488, 40, 1, 1, 1, 1, 15};

        resetN = 1'b1;
        hif.hitReady = 1'b0;
        hif2.hitReady = 1'b1;
        do_reset();

        // Reset values
        chk("rst_valid", hif.hitValid, 0);
        chk("rst_row", hif.hitRow, 0);
        chk("rst_col", hif.hitCol, 0);
        chk("rst_remaining", remaining, 80);
        chk("rst_allclear", allClear, 0);
        chk("rst_drop", dropPulse, 0);
        chk("rst_remaining2", remaining2, 2);

        // 40-cycle collision burst on one cell
        hif.hitReady = 1'b1;
        exp_q.push_back(mk(1, 2));
        offsetX = 11'd70; offsetY = 11'd40; InsideRectangle = 1'b1; collision = 1'b1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) chk("t1_latency", hif.hitValid, 1);
            if (hif.hitValid) nv++;
        end
        collision = 1'b0;
        repeat (2) begin
            tick();
            if (hif.hitValid) nv++;
        end
        chk("t1_pulses", nv, 1);
        chk("t1_remaining", remaining, 79);

        // Same cell, same frame: suppressed; new frame (same-cycle SOF): accepted
        hit(70, 40, 1, 1);
        chk("t2_dedupe", hif.hitValid, 0);
        exp_q.push_back(mk(1, 2));
        startOfFrame = 1'b1;
        hit(70, 40, 1, 1);
        startOfFrame = 1'b0;
        chk("t2_valid", hif.hitValid, 1);
        chk("t2_row", hif.hitRow, 1);
        chk("t2_col", hif.hitCol, 2);
        tick();
        chk("t2_single", hif.hitValid, 0);
        chk("t2_remaining", remaining, 78);

        // Fill FIFO with ready low, fifth hit dropped
        do_reset();
        hif.hitReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) exp_q.push_back(mk(0, c));
            hit(c * 32 + 5, 3, 1, 1);
            if (c == 3) chk("t3_no_drop_yet", dropPulse, 0);
            if (c == 4) chk("t3_drop", dropPulse, 1);
        end
        tick();
        chk("t3_drop_width", dropPulse, 0);
        chk("t3_hold_valid", hif.hitValid, 1);
        chk("t3_hold_row", hif.hitRow, 0);
        chk("t3_hold_col", hif.hitCol, 0);
        chk("t3_no_pop", remaining, 80);
        hif.hitReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_no_bubble", hif.hitValid, 1);
        end
        tick();
        chk("t3_empty", hif.hitValid, 0);
        chk("t3_remaining", remaining, 76);

        // Table: qualification, mapping corners, dedupe
        do_reset();
        hif.hitReady = 1'b1;
        nqual = 0;
        foreach (tbl[i]) begin
            if (tbl[i].qual) begin
                exp_q.push_back(mk(tbl[i].row, tbl[i].col));
                nqual++;
            end
            hit(tbl[i].ox, tbl[i].oy, tbl[i].ins, tbl[i].coll);
            chk("t4_valid", hif.hitValid, int'(tbl[i].qual));
            if (tbl[i].qual) begin
                chk("t4_row", hif.hitRow, tbl[i].row);
                chk("t4_col", hif.hitCol, tbl[i].col);
            end
            tick();
        end
        chk("t4_remaining", remaining, 80 - nqual);

        // Small counter saturation (TOTAL_HITS=2 instance)
        do_reset();
        hif.hitReady = 1'b1;
        hif2.hitReady = 1'b1;
        chk("t5_start", remaining2, 2);
        chk("t5_start_clear", allClear2, 0);
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(mk(2, c));
            hit(c * 32, 64, 1, 1);
            chk("t5_valid", hif2.hitValid, 1);
            tick();
            chk("t5_popped", hif2.hitValid, 0);
            chk("t5_remaining", remaining2, (c == 0) ? 1 : 0);
            chk("t5_allclear", allClear2, (c == 0) ? 0 : 1);
        end

        // newLevel flush with same-cycle pop and collision, then async reset
        do_reset();
        hif.hitReady = 1'b1;
        exp_q.push_back(mk(3, 3));
        hit(96, 96, 1, 1);
        tick();
        chk("t6_pre_remaining", remaining, 79);
        hif.hitReady = 1'b0;
        hit(0, 0, 1, 1);
        hit(32, 0, 1, 1);
        chk("t6_two_held", hif.hitValid, 1);
        hif.hitReady = 1'b1;
        newLevel = 1'b1;
        hit(64, 0, 1, 1);
        newLevel = 1'b0;
        chk("t6_flush_valid", hif.hitValid, 0);
        chk("t6_reload", remaining, 80);
        tick();
        chk("t6_no_push", hif.hitValid, 0);
        exp_q.push_back(mk(3, 3));
        hit(96, 96, 1, 1);
        tick();
        chk("t6_bitmap_cleared", remaining, 79);
        hif.hitReady = 1'b0;
        hit(96, 64, 1, 1);
        chk("t6_pre_valid", hif.hitValid, 1);
        chk("t6_pre_row", hif.hitRow, 2);
        chk("sb_drained", exp_q.size(), 0);
        #2;
        resetN = 1'b0;
        #1;
        chk("t6_rst_valid", hif.hitValid, 0);
        chk("t6_rst_row", hif.hitRow, 0);
        chk("t6_rst_col", hif.hitCol, 0);
        chk("t6_rst_remaining", remaining, 80);
        chk("t6_rst_allclear", allClear, 0);
        chk("t6_rst_drop", dropPulse, 0);
        exp_q.delete();
        tick();
        resetN = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
